// File: rtl/calc1_prio_sched.sv
// calc1 priority scheduler: steers requests from the four hold registers onto
// the adder (ALU1) and the shifter (ALU2). Each ALU has its own round-robin
// arbiter. Each requester may have one operation outstanding. Invalid commands
// are answered directly, without using an ALU.
//
// Handshake: a holdreg presents a nonzero command and keeps it until it sees
// its one-cycle ack. An ack means that the command was taken, either by an ALU
// or by the invalid-response path. While a requester is busy, its request is
// ignored. A requester is busy from the cycle after its grant through the
// cycle in which its result is valid.
module calc1_prio_sched #(
  parameter int ALU1_LAT = 3,
  parameter int ALU2_LAT = 3
) (
  input  logic       c_clk,
  input  logic       reset,
  input  logic [3:0] hold1_prio_req,
  input  logic [3:0] hold2_prio_req,
  input  logic [3:0] hold3_prio_req,
  input  logic [3:0] hold4_prio_req,
  output logic       prio_hold1_ack,
  output logic       prio_hold2_ack,
  output logic       prio_hold3_ack,
  output logic       prio_hold4_ack,
  output logic [3:0] prio_alu1_in_cmd,
  output logic [1:0] prio_alu1_in_req_id,
  output logic       prio_alu1_out_vld,
  output logic [1:0] prio_alu1_out_req_id,
  output logic [3:0] prio_alu2_in_cmd,
  output logic [1:0] prio_alu2_in_req_id,
  output logic       prio_alu2_out_vld,
  output logic [1:0] prio_alu2_out_req_id,
  output logic       prio_inv_vld,
  output logic [1:0] prio_inv_req_id
);

  logic [3:0] w_req [4];
  logic [3:0] w_cand1, w_cand2, w_cand_inv;
  logic [2:0] w_g1, w_g2, w_gi;
  logic [3:0] w_set, w_clr, w_ack_nxt;

  logic [3:0] r_busy;
  logic [1:0] r_rr1, r_rr2;
  logic [3:0] r_ack;
  logic [3:0] r_a1_cmd, r_a2_cmd;
  logic [1:0] r_a1_id, r_a2_id;
  logic       r_inv_vld;
  logic [1:0] r_inv_id;
  logic       r_p1_vld [ALU1_LAT+1];
  logic [1:0] r_p1_id  [ALU1_LAT+1];
  logic       r_p2_vld [ALU2_LAT+1];
  logic [1:0] r_p2_id  [ALU2_LAT+1];

  assign w_req[0] = hold1_prio_req;
  assign w_req[1] = hold2_prio_req;
  assign w_req[2] = hold3_prio_req;
  assign w_req[3] = hold4_prio_req;

  // First set bit of cand, searching upward from ptr with wrap. Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Classify every eligible (idle, nonzero) request by the ALU that serves it.
  always_comb begin
    w_cand1    = 4'b0000;
    w_cand2    = 4'b0000;
    w_cand_inv = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (!r_busy[i] && (w_req[i] != 4'd0)) begin
        if (w_req[i] == 4'd1 || w_req[i] == 4'd2)      w_cand1[i]    = 1'b1;
        else if (w_req[i] == 4'd5 || w_req[i] == 4'd6) w_cand2[i]    = 1'b1;
        else                                           w_cand_inv[i] = 1'b1;
      end
    end
  end

  // Grants: round-robin per ALU. For invalid commands the lowest index wins,
  // which is a search that starts from 0.
  assign w_g1 = rr_pick(w_cand1, r_rr1);
  assign w_g2 = rr_pick(w_cand2, r_rr2);
  assign w_gi = rr_pick(w_cand_inv, 2'd0);

  // Busy bookkeeping: set on ALU grant, cleared by the matching result strobe.
  // A requester cannot be set and cleared in the same cycle.
  // A busy requester is never granted.
  assign w_set = (w_g1[2] ? (4'b0001 << w_g1[1:0]) : 4'b0000)
               | (w_g2[2] ? (4'b0001 << w_g2[1:0]) : 4'b0000);
  assign w_clr = (r_p1_vld[ALU1_LAT] ? (4'b0001 << r_p1_id[ALU1_LAT]) : 4'b0000)
               | (r_p2_vld[ALU2_LAT] ? (4'b0001 << r_p2_id[ALU2_LAT]) : 4'b0000);
  assign w_ack_nxt = w_set | (w_gi[2] ? (4'b0001 << w_gi[1:0]) : 4'b0000);

  // Dispatch, ack and invalid-response registers, plus arbiter pointers and busy state.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_busy    <= 4'b0000;
      r_rr1     <= 2'd0;
      r_rr2     <= 2'd0;
      r_ack     <= 4'b0000;
      r_a1_cmd  <= 4'd0;
      r_a1_id   <= 2'd0;
      r_a2_cmd  <= 4'd0;
      r_a2_id   <= 2'd0;
      r_inv_vld <= 1'b0;
      r_inv_id  <= 2'd0;
    end else begin
      r_busy    <= (r_busy & ~w_clr) | w_set;
      r_ack     <= w_ack_nxt;
      r_a1_cmd  <= w_g1[2] ? w_req[w_g1[1:0]] : 4'd0;
      r_a1_id   <= w_g1[2] ? w_g1[1:0] : 2'd0;
      r_a2_cmd  <= w_g2[2] ? w_req[w_g2[1:0]] : 4'd0;
      r_a2_id   <= w_g2[2] ? w_g2[1:0] : 2'd0;
      r_inv_vld <= w_gi[2];
      r_inv_id  <= w_gi[2] ? w_gi[1:0] : 2'd0;
      if (w_g1[2]) r_rr1 <= w_g1[1:0] + 2'd1;
      if (w_g2[2]) r_rr2 <= w_g2[1:0] + 2'd1;
    end
  end

  // Completion pipelines. Stage 0 is the dispatch cycle.
  // Stage LAT drives the out strobe.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int k = 0; k <= ALU1_LAT; k++) begin
        r_p1_vld[k] <= 1'b0;
        r_p1_id[k]  <= 2'd0;
      end
      for (int k = 0; k <= ALU2_LAT; k++) begin
        r_p2_vld[k] <= 1'b0;
        r_p2_id[k]  <= 2'd0;
      end
    end else begin
      r_p1_vld[0] <= w_g1[2];
      r_p1_id[0]  <= w_g1[2] ? w_g1[1:0] : 2'd0;
      for (int k = 1; k <= ALU1_LAT; k++) begin
        r_p1_vld[k] <= r_p1_vld[k-1];
        r_p1_id[k]  <= r_p1_id[k-1];
      end
      r_p2_vld[0] <= w_g2[2];
      r_p2_id[0]  <= w_g2[2] ? w_g2[1:0] : 2'd0;
      for (int k = 1; k <= ALU2_LAT; k++) begin
        r_p2_vld[k] <= r_p2_vld[k-1];
        r_p2_id[k]  <= r_p2_id[k-1];
      end
    end
  end

  assign prio_hold1_ack       = r_ack[0];
  assign prio_hold2_ack       = r_ack[1];
  assign prio_hold3_ack       = r_ack[2];
  assign prio_hold4_ack       = r_ack[3];
  assign prio_alu1_in_cmd     = r_a1_cmd;
  assign prio_alu1_in_req_id  = r_a1_id;
  assign prio_alu1_out_vld    = r_p1_vld[ALU1_LAT];
  assign prio_alu1_out_req_id = r_p1_id[ALU1_LAT];
  assign prio_alu2_in_cmd     = r_a2_cmd;
  assign prio_alu2_in_req_id  = r_a2_id;
  assign prio_alu2_out_vld    = r_p2_vld[ALU2_LAT];
  assign prio_alu2_out_req_id = r_p2_id[ALU2_LAT];
  assign prio_inv_vld         = r_inv_vld;
  assign prio_inv_req_id      = r_inv_id;

endmodule
